// File: rtl/corner_adjuster_if.sv
// Bundle of the load / button / corner signals between the main FSM,
// the button debouncers and the corner adjuster.
interface corner_adjuster_if #(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 9
);
  logic                   set_corners;
  logic                   enable;
  logic [4*X_WIDTH-1:0]   auto_corners_x;
  logic [4*Y_WIDTH-1:0]   auto_corners_y;
  logic                   btn_up;
  logic                   btn_down;
  logic                   btn_left;
  logic                   btn_right;
  logic                   btn_select;
  logic [4*X_WIDTH-1:0]   corners_x;
  logic [4*Y_WIDTH-1:0]   corners_y;
  logic [1:0]             selected;
  logic                   corners_valid;

  modport master (
    output set_corners, enable, auto_corners_x, auto_corners_y,
           btn_up, btn_down, btn_left, btn_right, btn_select,
    input  corners_x, corners_y, selected, corners_valid
  );

  modport slave (
    input  set_corners, enable, auto_corners_x, auto_corners_y,
           btn_up, btn_down, btn_left, btn_right, btn_select,
    output corners_x, corners_y, selected, corners_valid
  );
endinterface

// File: rtl/corner_adjuster.sv
// Manual corner refinement: latches auto-detected corners, then lets the
// user pick a corner and nudge it with direction buttons (hold to repeat).
module corner_adjuster #(
  parameter int X_WIDTH       = 10,
  parameter int Y_WIDTH       = 9,
  parameter int X_MAX         = 639,
  parameter int Y_MAX         = 479,
  parameter int REPEAT_DELAY  = 16250000,
  parameter int REPEAT_PERIOD = 1625000
) (
  input logic              clk,
  input logic              reset_n,
  corner_adjuster_if.slave bus
);

  localparam int MAX_RPT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = (MAX_RPT > 2) ? $clog2(MAX_RPT) : 1;

  typedef enum logic [1:0] {WAIT_PRESS, FIRST_DELAY, REPEATING} state_e;
  typedef enum logic [2:0] {D_NONE, D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_e;

  logic [3:0][X_WIDTH-1:0] cx_q, cx_d;
  logic [3:0][Y_WIDTH-1:0] cy_q, cy_d;
  logic [1:0]              sel_q, sel_d;
  logic                    valid_q, valid_d;
  state_e                  state_q, state_d;
  dir_e                    dir_q, dir_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sel_prev_q, sel_prev_d;

  dir_e                    dir_now;
  logic                    do_step;
  logic                    sel_edge;

  // Decode buttons: exactly one pressed selects a direction, otherwise none.
  always_comb begin
    dir_now = D_NONE;
    unique case ({bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right})
      4'b1000: dir_now = D_UP;
      4'b0100: dir_now = D_DOWN;
      4'b0010: dir_now = D_LEFT;
      4'b0001: dir_now = D_RIGHT;
      default: dir_now = D_NONE;
    endcase
  end

  // Next-state: load has top priority, then disable, then motion FSM and select.
  always_comb begin
    cx_d       = cx_q;
    cy_d       = cy_q;
    sel_d      = sel_q;
    valid_d    = valid_q;
    state_d    = state_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    do_step    = 1'b0;
    sel_prev_d = bus.btn_select;
    sel_edge   = bus.btn_select & ~sel_prev_q;

    if (bus.set_corners) begin
      cx_d    = bus.auto_corners_x;
      cy_d    = bus.auto_corners_y;
      sel_d   = 2'd0;
      valid_d = 1'b1;
      state_d = WAIT_PRESS;
      dir_d   = D_NONE;
      cnt_d   = '0;
    end else if (!bus.enable) begin
      state_d = WAIT_PRESS;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        WAIT_PRESS: begin
          if (dir_now != D_NONE) begin
            do_step = 1'b1;
            dir_d   = dir_now;
            cnt_d   = '0;
            state_d = FIRST_DELAY;
          end
        end
        FIRST_DELAY: begin
          // A released or changed direction drops back without stepping.
          if (dir_now != dir_q) begin
            state_d = WAIT_PRESS;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
            do_step = 1'b1;
            cnt_d   = '0;
            state_d = REPEATING;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        REPEATING: begin
          if (dir_now != dir_q) begin
            state_d = WAIT_PRESS;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(REPEAT_PERIOD - 1)) begin
            do_step = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = WAIT_PRESS;
          cnt_d   = '0;
        end
      endcase

      // Step always targets the corner selected before any select edge this cycle.
      if (do_step) begin
        unique case (dir_now)
          D_UP:    if (cy_q[sel_q] != '0)                  cy_d[sel_q] = cy_q[sel_q] - Y_WIDTH'(1);
          D_DOWN:  if (cy_q[sel_q] <  Y_WIDTH'(Y_MAX))     cy_d[sel_q] = cy_q[sel_q] + Y_WIDTH'(1);
          D_LEFT:  if (cx_q[sel_q] != '0)                  cx_d[sel_q] = cx_q[sel_q] - X_WIDTH'(1);
          D_RIGHT: if (cx_q[sel_q] <  X_WIDTH'(X_MAX))     cx_d[sel_q] = cx_q[sel_q] + X_WIDTH'(1);
          default: ;
        endcase
      end

      if (sel_edge) begin
        sel_d   = sel_q + 2'd1;
        state_d = WAIT_PRESS;
        cnt_d   = '0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cx_q       <= '0;
      cy_q       <= '0;
      sel_q      <= 2'd0;
      valid_q    <= 1'b0;
      state_q    <= WAIT_PRESS;
      dir_q      <= D_NONE;
      cnt_q      <= '0;
      sel_prev_q <= 1'b0;
    end else begin
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      state_q    <= state_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      sel_prev_q <= sel_prev_d;
    end
  end

  assign bus.corners_x     = cx_q;
  assign bus.corners_y     = cy_q;
  assign bus.selected      = sel_q;
  assign bus.corners_valid = valid_q;

endmodule
